// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-2 Booth multiplier.
// Used by booth_step and booth_multiplier_core.
package booth_pkg;

  localparam int unsigned DEF_X = 4;
  localparam int unsigned DEF_Y = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } booth_state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 recoding of the {Q[0], Q_1} pair.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M into A,
// followed by an arithmetic right shift of {A, Q, Q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int X = DEF_X,
  parameter int Y = DEF_Y
) (
  input  logic [X+1:0] i_a,
  input  logic [Y-1:0] i_q,
  input  logic         i_q1,
  input  logic [X+1:0] i_m,
  output logic [X+1:0] o_a,
  output logic [Y-1:0] o_q,
  output logic         o_q1
);

  booth_op_t    w_op;
  logic [X+1:0] w_sum;

  assign w_op = booth_decode(i_q[0], i_q1);

  always_comb begin
    w_sum = i_a;
    case (w_op)
      OP_ADD:  w_sum = i_a + i_m;
      OP_SUB:  w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  // A is one bit wider than M needs, so the sign bit of w_sum is always valid.
  assign o_a  = {w_sum[X+1], w_sum[X+1:1]};
  assign o_q  = {w_sum[0], i_q[Y-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_multiplier_core.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// Optional BOOTH_OVF_FLAG_EN adds an ovf output flagging a truncated product.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting; loads operands on any edge where en is high
// ST_RUN  | performing Booth steps; last step writes P_final and pulses done
module booth_multiplier_core
  import booth_pkg::*;
#(
  parameter int X = DEF_X,
  parameter int Y = DEF_Y
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [X:0]     m,
  input  logic [Y-1:0]   r,
  output logic [X+Y-1:0] P_final,
  output logic           done,
  output logic           busy
`ifdef BOOTH_OVF_FLAG_EN
  ,output logic          ovf
`endif
);

  localparam int CW = $clog2(Y + 1);

  booth_state_t r_state;
  booth_state_t w_state_nxt;

  logic [X+1:0]   r_m;
  logic [X+1:0]   r_a;
  logic [Y-1:0]   r_q;
  logic           r_q1;
  logic [CW-1:0]  r_cnt;
  logic [X+Y-1:0] r_p_final;
  logic           r_done;

  logic [X+1:0]   w_a_nxt;
  logic [Y-1:0]   w_q_nxt;
  logic           w_q1_nxt;
  logic           w_load;
  logic           w_step;
  logic           w_last;

  booth_step #(
    .X (X),
    .Y (Y)
  ) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_nxt),
    .o_q  (w_q_nxt),
    .o_q1 (w_q1_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_p_final <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_m   <= {m[X], m};
        r_a   <= '0;
        r_q   <= r;
        r_q1  <= 1'b0;
        r_cnt <= CW'(Y);
      end else if (w_step) begin
        r_a   <= w_a_nxt;
        r_q   <= w_q_nxt;
        r_q1  <= w_q1_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          // Low X+Y bits of {A,Q}; the upper bits wrap away.
          r_p_final <= {w_a_nxt[X-1:0], w_q_nxt};
          r_done    <= 1'b1;
        end
      end
    end
  end

`ifdef BOOTH_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (w_a_nxt[X+1] != w_a_nxt[X-1]) || (w_a_nxt[X] != w_a_nxt[X-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign P_final = r_p_final;
  assign done    = r_done;
  assign busy    = (r_state == ST_RUN);

endmodule

// File: tb/tb_booth_multiplier_core.sv
// Directed testbench for booth_multiplier_core at X=4, Y=4.
// Define BOOTH_OVF_FLAG_EN to also check the ovf output.
module tb_booth_multiplier_core;

  localparam int X   = 4;
  localparam int Y   = 4;
  localparam int LAT = Y + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [X:0]     m;
  logic [Y-1:0]   r;
  logic [X+Y-1:0] P_final;
  logic           done;
  logic           busy;
`ifdef BOOTH_OVF_FLAG_EN
  logic           ovf;
`endif

  int checks = 0;
  int errors = 0;

  booth_multiplier_core #(.X(X), .Y(Y)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .m       (m),
    .r       (r),
    .P_final (P_final),
    .done    (done),
    .busy    (busy)
`ifdef BOOTH_OVF_FLAG_EN
    ,.ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Launch one operation and count edges (sample edge included) until done.
  task automatic do_op(input int mv, input int rv,
                       output logic [X+Y-1:0] p, output int lat);
    @(negedge clk);
    m   = (X+1)'(mv);
    r   = Y'(rv);
    en  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
    p  = P_final;
    en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (P_final !== 8'h00) begin errors++; $display("FAIL reset_p got %h want 00", P_final); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef BOOTH_OVF_FLAG_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
  endtask

  typedef struct { int mv; int rv; logic [7:0] exp; logic ovf_exp; } vec_t;

  task automatic test_products();
    vec_t vecs[6];
    logic [X+Y-1:0] p;
    int lat;
    vecs[0] = '{4,   6,  8'h18, 1'b0};
    vecs[1] = '{4,   -8, 8'hE0, 1'b0};
    vecs[2] = '{1,   -6, 8'hFA, 1'b0};
    vecs[3] = '{-5,  -8, 8'h28, 1'b0};
    vecs[4] = '{3,   -4, 8'hF4, 1'b0};
    vecs[5] = '{-16, -8, 8'h80, 1'b1};
    foreach (vecs[i]) begin
      do_op(vecs[i].mv, vecs[i].rv, p, lat);
      checks++;
      if (p !== vecs[i].exp) begin
        errors++; $display("FAIL product[%0d] m=%0d r=%0d got %h want %h", i, vecs[i].mv, vecs[i].rv, p, vecs[i].exp);
      end
      checks++;
      if (lat !== LAT) begin
        errors++; $display("FAIL latency[%0d] got %0d want %0d", i, lat, LAT);
      end
`ifdef BOOTH_OVF_FLAG_EN
      checks++;
      if (ovf !== vecs[i].ovf_exp) begin
        errors++; $display("FAIL ovf[%0d] got %b want %b", i, ovf, vecs[i].ovf_exp);
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL done_pulse[%0d] done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_operand_hold();
    int lat;
    @(negedge clk);
    m = 5'(3); r = 4'(-4); en = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin m = 5'(7); r = 4'(5); end
    end while (!done && lat < 40);
    en = 1'b0;
    checks++;
    if (P_final !== 8'hF4) begin errors++; $display("FAIL operand_hold got %h want f4", P_final); end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL operand_hold_lat got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int edges;
    int done_at[2];
    int nd;
    logic [X+Y-1:0] res[2];
    @(negedge clk);
    m = 5'(2); r = 4'(3); en = 1'b1;
    edges = 0; nd = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin m = 5'(-3); r = 4'(5); end
      if (done) begin done_at[nd] = edges; res[nd] = P_final; nd++; end
    end while (nd < 2 && edges < 60);
    en = 1'b0;
    checks++;
    if (nd !== 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", nd);
    end else begin
      checks++;
      if (res[0] !== 8'h06) begin errors++; $display("FAIL b2b_first got %h want 06", res[0]); end
      checks++;
      if (res[1] !== 8'hF1) begin errors++; $display("FAIL b2b_second got %h want f1", res[1]); end
      checks++;
      if (done_at[1] - done_at[0] !== LAT) begin
        errors++; $display("FAIL b2b_spacing got %0d want %0d", done_at[1] - done_at[0], LAT);
      end
    end
  endtask

  task automatic test_en_drop();
    int lat;
    int stray;
    @(negedge clk);
    m = 5'(6); r = 4'(5); en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL en_drop_busy got %b want 1", busy); end
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
    checks++;
    if (P_final !== 8'h1E || lat !== LAT) begin
      errors++; $display("FAIL en_drop_result got %h lat %0d want 1e lat %0d", P_final, lat, LAT);
    end
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || done) stray++;
    end
    checks++;
    if (stray !== 0 || P_final !== 8'h1E) begin
      errors++; $display("FAIL en_drop_idle stray %0d p %h want 0 1e", stray, P_final);
    end
  endtask

  task automatic test_reset_mid();
    logic [X+Y-1:0] p;
    int lat;
    @(negedge clk);
    m = 5'(7); r = 4'(7); en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (P_final !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid got p=%h done=%b busy=%b want 00 0 0", P_final, done, busy);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(-5, -8, p, lat);
    checks++;
    if (p !== 8'h28 || lat !== LAT) begin
      errors++; $display("FAIL reset_recover got %h lat %0d want 28 lat %0d", p, lat, LAT);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    m     = '0;
    r     = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_products();
    test_operand_hold();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
